proj1_alu_seq: RTL and testbench
================================

# proj1_alu_seq

Instruction sequencer that drives the proj1 8-bit ALU from the issuing side. It accepts 16-bit instruction words over a valid/ready handshake and reads operands from a 16x8 register file. It issues operands, opcode and carry-in to the ALU, waits out the ALU's registered latency, and writes results and C/N/Z status back. It sits between the instruction source (testbench or fetch unit) and the ALU.

## Interface
- ALU_LAT, 2, ALU edges from operand capture to registered result; legal values 1..4.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_valid  in  1  instruction word present.
- instr_ready  out  1  sequencer can accept; high only in IDLE and not in reset.
- instr  in  16  [15:8] opcode, [7:4] rd index, [3:0] rr index.
- rf_we  in  1  preload write strobe; honoured only in IDLE.
- rf_waddr  in  4  preload address.
- rf_wdata  in  8  preload data.
- rf_raddr  in  4  debug read address.
- rf_rdata  out  8  R[rf_raddr], combinational.
- alu_opcode  out  8  opcode to ALU.
- alu_rd  out  8  R[rd] to ALU.
- alu_rr  out  8  R[rr] to ALU.
- alu_ci  out  1  current C flag.
- alu_data  in  16  ALU result.
- alu_co, alu_no, alu_zo  in  1 each  ALU flags.
- flags  out  3  {C,N,Z}.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse, instruction retired.
- illegal  out  1  one-cycle pulse alongside done for an undecoded opcode.

## Operation
- Reset values:
  - All 16 registers, flags, alu_opcode, alu_rd, alu_rr, alu_ci, done, illegal and busy are 0.
  - State is IDLE. instr_ready is 0 while rst is high.
- Opcode classes by opcode[7:4]:
  - 0000 shift: low 2 bits select lsl/asr/rol/ror.
  - 0100 mul.
  - 1000 and, 1001 or, 1010 xor.
  - 1011 neg: legal only when opcode[1:0]==00.
  - 1100 add, 1101 addc, 1110 sub, 1111 subc.
  - All other encodings are illegal.
- FSM states: IDLE, ISSUE, WAIT, WB.
  - IDLE -> ISSUE on instr_valid & instr_ready. The instruction word is latched.
  - IDLE -> WB directly if the instruction is illegal. No ALU issue, no writeback, no flag change; done and illegal pulse.
  - ISSUE -> WAIT, or -> WB when ALU_LAT==1.
  - WAIT holds for ALU_LAT-1 cycles (down-counter), then -> WB.
  - WB -> IDLE unconditionally.
- ISSUE loads alu_opcode, alu_rd=R[rd], alu_rr=R[rr] and alu_ci=C. These stay stable through WAIT and WB. They return to 0 in IDLE.
- Writeback in WB, registered at the end of the WB cycle:
  - mul: R[rd] <= alu_data[7:0]; R[(rd+1) mod 16] <= alu_data[15:8]. rd=15 wraps the high byte into R0.
  - Other legal ops: R[rd] <= alu_data[7:0].
- Flag update in WB:
  - shift, add, addc, sub, subc: C,N,Z <= alu_co, alu_no, alu_zo.
  - mul: C <= alu_data[15], Z <= (alu_data==0); N is unchanged.
  - and/or/xor: N <= alu_data[7], Z <= (alu_data[7:0]==0); C is unchanged.
  - neg: same as and/or/xor, plus C <= (alu_data[7:0]!=0).
- Preload: a write with rf_we in IDLE updates R[rf_waddr] at the clock edge. rf_we outside IDLE is ignored.
- Preload and instruction accept in the same cycle: both take effect. ISSUE reads the preloaded value.
- rd==rr is legal; both operands carry the same value.

## Timing
- Accept edge E0 starts ISSUE. The ALU captures operands at E1 and presents its result after ALU_LAT edges. WB samples it.
- done is high during WB, which is cycle ALU_LAT+1 after E0. RF and flags are visible from the next cycle.
- Back-to-back throughput: one instruction per ALU_LAT+2 cycles. The next instruction reads the updated register file.
- Illegal instruction: done and illegal high in the cycle after E0; ready again one cycle later.
- rst asserted mid-operation: abort immediately, no writeback, all state at reset values. The first accept is possible in the cycle after rst deasserts.
- instr_valid may drop at any time without acceptance. Nothing is latched unless valid&ready at an edge.

## Test plan
- Preload R1=0x0F, R2=0xF1; issue add rd=1,rr=2 (0xC012) -> done at cycle ALU_LAT+1; R1=0x00; flags C=1,N=0,Z=1.
- Preload R3=0x10, R4=0x20; issue mul rd=3,rr=4 (0x4034) -> R3=0x00, R4=0x02, C=0, Z=0. Then rd=15 with R15=0xFF, R0 as rr=0xFF -> R15=0x01, R0=0xFE.
- C=1, R5=0x80; issue rol (0x0252) -> alu_ci=1 during ISSUE; R5=0x01, C=1, N=0, Z=0. Then neg R6=0x00 (0xB060) -> R6=0x00, C=0, Z=1.
- Opcode 0x20 and opcode 0xB1 -> illegal and done pulse one cycle after accept; RF and flags unchanged; no alu_opcode change.
- Hold instr_valid high with 3 instructions, each dependent on the prior rd -> instr_ready pulses every ALU_LAT+2 cycles; dependency results correct; rf_we during busy ignored.
- Assert rst during WAIT of an add -> no RF write, flags 0, busy 0 asynchronously; the next instruction after release executes normally.

Source files
------------

// File: rtl/proj1_alu_seq.sv
// proj1_alu_seq: issues instruction words to the proj1 8-bit ALU,
// waits out its latency and writes results and C/N/Z back.
module proj1_alu_seq #(
    parameter int ALU_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    input  logic        rf_we,
    input  logic [3:0]  rf_waddr,
    input  logic [7:0]  rf_wdata,
    input  logic [3:0]  rf_raddr,
    output logic [7:0]  rf_rdata,
    output logic [7:0]  alu_opcode,
    output logic [7:0]  alu_rd,
    output logic [7:0]  alu_rr,
    output logic        alu_ci,
    input  logic [15:0] alu_data,
    input  logic        alu_co,
    input  logic        alu_no,
    input  logic        alu_zo,
    output logic [2:0]  flags,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB
    } state_t;

    localparam logic [1:0] WAIT_INIT =
        (ALU_LAT > 1) ? 2'(ALU_LAT - 2) : 2'd0;

    state_t     state;
    state_t     state_nx;
    logic [7:0] rf [16];
    logic [3:0] rd_q;
    logic [3:0] rd_hi;
    logic       ill_q;
    logic [1:0] cnt;
    logic       c_q;
    logic       n_q;
    logic       z_q;
    logic       accept;
    logic       legal_in;
    logic       wb;
    logic [7:0] rd_fwd;
    logic [7:0] rr_fwd;
    logic       is_shift;
    logic       is_mul;
    logic       is_log;
    logic       is_neg;
    logic       is_arith;

    assign instr_ready = (state == IDLE) && !rst;
    assign accept      = instr_valid && instr_ready;
    assign busy        = (state != IDLE);
    assign done        = (state == WB);
    assign illegal     = done && ill_q;
    assign flags       = {c_q, n_q, z_q};
    assign rf_rdata    = rf[rf_raddr];
    assign wb          = (state == WB) && !ill_q;
    assign rd_hi       = rd_q + 4'd1;

    always_comb begin
        legal_in = 1'b0;
        unique case (instr[15:12])
            4'h0, 4'h4:       legal_in = 1'b1;
            4'h8, 4'h9, 4'hA: legal_in = 1'b1;
            4'hB:             legal_in = (instr[9:8] == 2'b00);
            4'hC, 4'hD:       legal_in = 1'b1;
            4'hE, 4'hF:       legal_in = 1'b1;
            default:          legal_in = 1'b0;
        endcase
    end

    // A preload landing in the accept cycle must reach the operands.
    assign rd_fwd = (rf_we && rf_waddr == instr[7:4]) ?
                    rf_wdata : rf[instr[7:4]];
    assign rr_fwd = (rf_we && rf_waddr == instr[3:0]) ?
                    rf_wdata : rf[instr[3:0]];

    // The latched opcode only holds legal encodings outside IDLE.
    assign is_shift = (alu_opcode[7:4] == 4'h0);
    assign is_mul   = (alu_opcode[7:4] == 4'h4);
    assign is_log   = alu_opcode[7:4] inside {4'h8, 4'h9, 4'hA};
    assign is_neg   = (alu_opcode[7:4] == 4'hB);
    assign is_arith = (alu_opcode[7:6] == 2'b11);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = legal_in ? ISSUE : WB;
            ISSUE:   state_nx = (ALU_LAT == 1) ? WB : WAIT;
            WAIT:    if (cnt == 2'd0) state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            rd_q  <= 4'd0;
            ill_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                rd_q  <= instr[7:4];
                ill_q <= !legal_in;
            end
            if (state == ISSUE) begin
                cnt <= WAIT_INIT;
            end else if (state == WAIT && cnt != 2'd0) begin
                cnt <= cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_opcode <= 8'h00;
            alu_rd     <= 8'h00;
            alu_rr     <= 8'h00;
            alu_ci     <= 1'b0;
        end else if (accept && legal_in) begin
            alu_opcode <= instr[15:8];
            alu_rd     <= rd_fwd;
            alu_rr     <= rr_fwd;
            alu_ci     <= c_q;
        end else if (state == WB) begin
            alu_opcode <= 8'h00;
            alu_rd     <= 8'h00;
            alu_rr     <= 8'h00;
            alu_ci     <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
        end else if (state == IDLE && rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end else if (wb) begin
            rf[rd_q] <= alu_data[7:0];
            if (is_mul) rf[rd_hi] <= alu_data[15:8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q <= 1'b0;
            n_q <= 1'b0;
            z_q <= 1'b0;
        end else if (wb) begin
            unique case (1'b1)
                is_shift, is_arith: begin
                    c_q <= alu_co;
                    n_q <= alu_no;
                    z_q <= alu_zo;
                end
                is_mul: begin
                    c_q <= alu_data[15];
                    z_q <= (alu_data == 16'h0000);
                end
                is_log: begin
                    n_q <= alu_data[7];
                    z_q <= (alu_data[7:0] == 8'h00);
                end
                is_neg: begin
                    c_q <= (alu_data[7:0] != 8'h00);
                    n_q <= alu_data[7];
                    z_q <= (alu_data[7:0] == 8'h00);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_proj1_alu_seq.sv
// Bench for proj1_alu_seq: stub ALU with registered latency plus
// an architectural model of the register file and flags.
module tb_proj1_alu_seq;

    localparam int ALU_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic [3:0]  rf_raddr;
    logic [7:0]  rf_rdata;
    logic [7:0]  alu_opcode;
    logic [7:0]  alu_rd;
    logic [7:0]  alu_rr;
    logic        alu_ci;
    logic [15:0] alu_data;
    logic        alu_co;
    logic        alu_no;
    logic        alu_zo;
    logic [2:0]  flags;
    logic        busy;
    logic        done;
    logic        illegal;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] m_rf [16];
    logic       m_c;
    logic       m_n;
    logic       m_z;

    logic [3:0] cl_tab [10] = '{4'h0, 4'h4, 4'h8, 4'h9, 4'hA,
                                4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    always #50 clk = ~clk;

    proj1_alu_seq #(.ALU_LAT(ALU_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .alu_opcode  (alu_opcode),
        .alu_rd      (alu_rd),
        .alu_rr      (alu_rr),
        .alu_ci      (alu_ci),
        .alu_data    (alu_data),
        .alu_co      (alu_co),
        .alu_no      (alu_no),
        .alu_zo      (alu_zo),
        .flags       (flags),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal)
    );

    // Returns {co, no, zo, data}; flags are junk for non-arith ops.
    function automatic logic [18:0] alu_fn(input logic [7:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic       ci);
        logic [8:0] s;
        logic [7:0] r;
        s = 9'd0;
        r = 8'd0;
        case (op[7:4])
            4'h0: begin
                case (op[1:0])
                    2'd0: s = {a, 1'b0};
                    2'd1: s = {a[0], a[7], a[7:1]};
                    2'd2: s = {a, ci};
                    default: s = {a[0], ci, a[7:1]};
                endcase
                return {s[8], s[7], s[7:0] == 8'h00, 8'hA5, s[7:0]};
            end
            4'h4: return {3'b111, 16'(a) * 16'(b)};
            4'h8: r = a & b;
            4'h9: r = a | b;
            4'hA: r = a ^ b;
            4'hB: r = 8'h00 - a;
            4'hC, 4'hD, 4'hE, 4'hF: begin
                if (op[5]) s = {1'b0, a} - {1'b0, b} - 9'(op[4] & ci);
                else       s = {1'b0, a} + {1'b0, b} + 9'(op[4] & ci);
                return {s[8], s[7], s[7:0] == 8'h00, 8'hA5, s[7:0]};
            end
            default: r = 8'h00;
        endcase
        return {3'b111, 8'hA5, r};
    endfunction

    logic [18:0] pipe [ALU_LAT];
    always @(posedge clk) begin
        pipe[0] <= alu_fn(alu_opcode, alu_rd, alu_rr, alu_ci);
        for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign {alu_co, alu_no, alu_zo, alu_data} = pipe[ALU_LAT-1];

    function automatic logic legal(input logic [7:0] op);
        if (op[7:4] == 4'hB) return op[1:0] == 2'b00;
        return op[7:4] inside {4'h0, 4'h4, 4'h8, 4'h9, 4'hA,
                               4'hC, 4'hD, 4'hE, 4'hF};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
        {m_c, m_n, m_z} = 3'b000;
    endtask

    task automatic model_exec(input logic [15:0] w);
        logic [18:0] v;
        logic [15:0] d;
        logic [3:0]  rd;
        logic [3:0]  rh;
        rd = w[7:4];
        rh = rd + 4'd1;
        if (!legal(w[15:8])) return;
        v = alu_fn(w[15:8], m_rf[rd], m_rf[w[3:0]], m_c);
        d = v[15:0];
        m_rf[rd] = d[7:0];
        if (w[15:12] == 4'h4) begin
            m_rf[rh] = d[15:8];
            m_c = d[15];
            m_z = (d == 16'h0);
        end else if (w[15:12] == 4'h0 || w[15:14] == 2'b11) begin
            {m_c, m_n, m_z} = v[18:16];
        end else begin
            m_n = d[7];
            m_z = (d[7:0] == 8'h00);
            if (w[15:12] == 4'hB) m_c = (d[7:0] != 8'h00);
        end
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 16; i++) begin
            rf_raddr = 4'(i);
            #1;
            chk($sformatf("%s.r%0d", tag, i), 16'(rf_rdata), 16'(m_rf[i]));
        end
        chk($sformatf("%s.flags", tag), 16'(flags), 16'({m_c, m_n, m_z}));
    endtask

    task automatic preload(input logic [3:0] a, input logic [7:0] d);
        rf_we    = 1'b1;
        rf_waddr = a;
        rf_wdata = d;
        @(negedge clk);
        rf_we = 1'b0;
        m_rf[a] = d;
    endtask

    task automatic run(input string tag, input logic [15:0] w,
                       input logic pl, input logic [3:0] pa,
                       input logic [7:0] pd);
        int cyc;
        chk($sformatf("%s.rdy", tag), 16'(instr_ready), 16'd1);
        instr_valid = 1'b1;
        instr       = w;
        rf_we       = pl;
        rf_waddr    = pa;
        rf_wdata    = pd;
        if (pl) m_rf[pa] = pd;
        @(negedge clk);
        instr_valid = 1'b0;
        rf_we       = 1'b0;
        cyc = 1;
        if (legal(w[15:8])) begin
            chk($sformatf("%s.op", tag), 16'(alu_opcode), 16'(w[15:8]));
            chk($sformatf("%s.ard", tag), 16'(alu_rd), 16'(m_rf[w[7:4]]));
            chk($sformatf("%s.arr", tag), 16'(alu_rr), 16'(m_rf[w[3:0]]));
            chk($sformatf("%s.aci", tag), 16'(alu_ci), 16'(m_c));
            while (!done && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            chk($sformatf("%s.lat", tag), 16'(cyc), 16'(ALU_LAT + 1));
            chk($sformatf("%s.ill", tag), 16'(illegal), 16'd0);
        end else begin
            chk($sformatf("%s.done", tag), 16'(done), 16'd1);
            chk($sformatf("%s.ill", tag), 16'(illegal), 16'd1);
            chk($sformatf("%s.op0", tag), 16'(alu_opcode), 16'd0);
        end
        @(negedge clk);
        chk($sformatf("%s.idle", tag), 16'({busy, done, instr_ready}),
            16'b001);
        model_exec(w);
        check_state(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [15:0] w3 [3];
        int          acc [3];
        int          k;
        int          cyc;
        logic [7:0]  op;

        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        rf_we       = 1'b0;
        rf_waddr    = 4'd0;
        rf_wdata    = 8'd0;
        rf_raddr    = 4'd0;
        model_reset();

        @(negedge clk);
        chk("rst.ready", 16'(instr_ready), 16'd0);
        chk("rst.ctl", 16'({busy, done, illegal}), 16'd0);
        chk("rst.alu", {alu_opcode, alu_rd}, 16'd0);
        chk("rst.alu2", {7'd0, alu_ci, alu_rr}, 16'd0);
        check_state("rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel.ready", 16'(instr_ready), 16'd1);
        @(negedge clk);

        preload(4'd1, 8'h0F);
        preload(4'd2, 8'hF1);
        run("add", 16'hC012, 1'b0, 4'd0, 8'd0);
        chk("add.r1", 16'(m_rf[1]), 16'h00);
        chk("add.flags", 16'(flags), 16'b101);

        preload(4'd3, 8'h10);
        preload(4'd4, 8'h20);
        run("mul", 16'h4034, 1'b0, 4'd0, 8'd0);
        chk("mul.flags_cz", 16'({flags[2], flags[0]}), 16'b00);
        preload(4'd15, 8'hFF);
        preload(4'd0, 8'hFF);
        run("mulwrap", 16'h40F0, 1'b0, 4'd0, 8'd0);
        chk("mulwrap.r0", 16'(m_rf[0]), 16'hFE);

        preload(4'd5, 8'h80);
        run("rol", 16'h0252, 1'b0, 4'd0, 8'd0);
        chk("rol.flags", 16'(flags), 16'b100);
        run("neg", 16'hB060, 1'b1, 4'd6, 8'h00);
        chk("neg.flags", 16'({flags[2], flags[0]}), 16'b01);
        run("fwd", 16'hC077, 1'b1, 4'd7, 8'h33);

        run("ill20", 16'h2012, 1'b0, 4'd0, 8'd0);
        run("illB1", 16'hB112, 1'b0, 4'd0, 8'd0);

        w3[0] = 16'hC012;
        w3[1] = 16'h4031;
        w3[2] = 16'h9043;
        k   = 0;
        cyc = 0;
        instr_valid = 1'b1;
        while (k < 3 && cyc < 100) begin
            instr    = w3[k];
            rf_we    = busy;
            rf_waddr = 4'd9;
            rf_wdata = 8'h5A;
            if (instr_ready) begin
                acc[k] = cyc;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        instr_valid = 1'b0;
        rf_we       = 1'b0;
        cyc = 0;
        while (busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b.count", 16'(k), 16'd3);
        chk("b2b.gap1", 16'(acc[1] - acc[0]), 16'(ALU_LAT + 2));
        chk("b2b.gap2", 16'(acc[2] - acc[1]), 16'(ALU_LAT + 2));
        for (int i = 0; i < 3; i++) model_exec(w3[i]);
        check_state("b2b");

        preload(4'd1, 8'h40);
        preload(4'd2, 8'h02);
        instr       = 16'hC012;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("abort.busy_pre", 16'(busy), 16'd1);
        rst = 1'b1;
        #1;
        chk("abort.ctl", 16'({busy, done, instr_ready}), 16'd0);
        model_reset();
        check_state("abort");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort.ready", 16'(instr_ready), 16'd1);
        @(negedge clk);
        preload(4'd1, 8'h40);
        run("post_rst", 16'hE121, 1'b1, 4'd2, 8'h02);

        for (int it = 0; it < 40; it++) begin
            op = 8'($urandom);
            if ($urandom_range(3) != 0) op[7:4] = cl_tab[$urandom_range(9)];
            run($sformatf("rnd%0d", it), {op, 8'($urandom)},
                1'($urandom_range(1)), 4'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
